// File: rtl/align_shift_pipe_if.sv
// Valid/ready word bundle for align_shift_pipe.
// The upstream side carries a significand with its shift controls; the downstream side carries the shifted word and sticky.
interface align_shift_pipe_if #(
  parameter int SWR = 26,
  parameter int EWR = 5
) ();
  logic           valid_i;
  logic           ready_o;
  logic [SWR-1:0] Data_i;
  logic           left_right_i;
  logic [EWR-1:0] Shift_Value_i;
  logic           bit_shift_i;
  logic           valid_o;
  logic           ready_i;
  logic [SWR-1:0] Data_o;
  logic           sticky_o;

  // A word moves on a rising edge where valid and ready are both 1. valid and its payload
  // stay stable until that edge. ready may change freely and never waits on valid.
  modport slave (
    input  valid_i, Data_i, left_right_i, Shift_Value_i, bit_shift_i, ready_i,
    output ready_o, valid_o, Data_o, sticky_o
  );
  modport master (
    output valid_i, Data_i, left_right_i, Shift_Value_i, bit_shift_i, ready_i,
    input  ready_o, valid_o, Data_o, sticky_o
  );
endinterface

// File: rtl/align_shift_pipe.sv
// Pipelined logarithmic left/right barrel shifter with fill bit and right-shift sticky.
// Register cuts are selectable per level, and the output register is always present.
module align_shift_pipe #(
  parameter int             SWR       = 26,
  parameter int             EWR       = 5,
  parameter logic [EWR-1:0] PIPE_CUT  = 5'b00100,
  parameter bit             STICKY_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  align_shift_pipe_if.slave bus
);
  // The last level always registers, so the top bit of PIPE_CUT has no effect.
  localparam logic [EWR-1:0] REG_MASK = {1'b1, PIPE_CUT[EWR-2:0]};

  typedef struct packed {
    logic           v;
    logic [SWR-1:0] d;
    logic           left;
    logic           fill;
    logic [EWR-1:0] amt;
    logic           sat;
    logic           stk;
  } stage_t;

  stage_t [EWR-1:0] w_in;
  stage_t [EWR-1:0] w_out;
  logic   [EWR-1:0] w_en;
  logic             w_sat;
  stage_t [EWR-1:0] r_q;

  // On a saturating right shift, later levels drop fill bits rather than data bits.
  // Sticky is therefore taken once from the whole input word, and the per-level OR is gated off.
  function automatic stage_t level_f(stage_t s, int k);
    stage_t o;
    int     sh;
    o  = s;
    sh = 1 << k;
    if (s.amt[k]) begin
      for (int i = 0; i < SWR; i++) begin
        if (s.left) o.d[i] = (i >= sh) ? s.d[i-sh] : s.fill;
        else        o.d[i] = (i + sh < SWR) ? s.d[i+sh] : s.fill;
        if (!s.left && !s.sat && i < sh) o.stk = o.stk | s.d[i];
      end
    end
    return o;
  endfunction

  always_comb begin
    w_sat = int'(bus.Shift_Value_i) >= SWR;
    w_in  = '0;
    w_out = '0;
    w_en  = '0;
    w_in[0] = '{v: bus.valid_i, d: bus.Data_i, left: bus.left_right_i, fill: bus.bit_shift_i,
                amt: bus.Shift_Value_i, sat: w_sat,
                stk: w_sat & ~bus.left_right_i & (|bus.Data_i)};
    w_out[0] = level_f(w_in[0], 0);
    for (int k = 1; k < EWR; k++) begin
      w_in[k]  = REG_MASK[k-1] ? r_q[k-1] : w_out[k-1];
      w_out[k] = level_f(w_in[k], k);
    end
    // Each level reports the load enable of the first register at or after it.
    w_en[EWR-1] = ~r_q[EWR-1].v | bus.ready_i;
    for (int k = EWR - 2; k >= 0; k--)
      w_en[k] = REG_MASK[k] ? (~r_q[k].v | w_en[k+1]) : w_en[k+1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else begin
      for (int k = 0; k < EWR; k++) begin
        if (REG_MASK[k] && w_en[k]) begin
          if (w_out[k].v) r_q[k]   <= w_out[k];
          else            r_q[k].v <= 1'b0;
        end
      end
    end
  end

  assign bus.ready_o  = rst & w_en[0];
  assign bus.valid_o  = r_q[EWR-1].v;
  assign bus.Data_o   = r_q[EWR-1].d;
  assign bus.sticky_o = STICKY_EN & r_q[EWR-1].stk;
endmodule

// File: tb/tb_align_shift_pipe.sv
// Directed bench for align_shift_pipe: single words, stalled stream, async reset, and a PIPE_CUT latency/exactness sweep.
module tb_align_shift_pipe;
  localparam int SWR = 26;
  localparam int EWR = 5;
  localparam int W   = SWR + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  align_shift_pipe_if #(.SWR(SWR), .EWR(EWR)) bus ();
  align_shift_pipe_if #(.SWR(SWR), .EWR(EWR)) sb0 ();
  align_shift_pipe_if #(.SWR(SWR), .EWR(EWR)) sb1 ();
  align_shift_pipe_if #(.SWR(SWR), .EWR(EWR)) sb2 ();

  align_shift_pipe #(.SWR(SWR), .EWR(EWR), .PIPE_CUT(5'b00100), .STICKY_EN(1'b1))
    u_dut (.clk(clk), .rst(rst), .bus(bus));
  align_shift_pipe #(.SWR(SWR), .EWR(EWR), .PIPE_CUT(5'b00000), .STICKY_EN(1'b1))
    u_cut0 (.clk(clk), .rst(rst), .bus(sb0));
  align_shift_pipe #(.SWR(SWR), .EWR(EWR), .PIPE_CUT(5'b01010), .STICKY_EN(1'b1))
    u_cut1 (.clk(clk), .rst(rst), .bus(sb1));
  align_shift_pipe #(.SWR(SWR), .EWR(EWR), .PIPE_CUT(5'b01111), .STICKY_EN(1'b1))
    u_cut2 (.clk(clk), .rst(rst), .bus(sb2));

  // Shared stimulus for the three sweep instances
  logic           sw_valid, sw_left, sw_fill, sw_ready;
  logic [EWR-1:0] sw_amt;
  logic [SWR-1:0] sw_data;
  assign sb0.valid_i = sw_valid; assign sb0.left_right_i = sw_left; assign sb0.bit_shift_i = sw_fill;
  assign sb0.Shift_Value_i = sw_amt; assign sb0.Data_i = sw_data; assign sb0.ready_i = sw_ready;
  assign sb1.valid_i = sw_valid; assign sb1.left_right_i = sw_left; assign sb1.bit_shift_i = sw_fill;
  assign sb1.Shift_Value_i = sw_amt; assign sb1.Data_i = sw_data; assign sb1.ready_i = sw_ready;
  assign sb2.valid_i = sw_valid; assign sb2.left_right_i = sw_left; assign sb2.bit_shift_i = sw_fill;
  assign sb2.Shift_Value_i = sw_amt; assign sb2.Data_i = sw_data; assign sb2.ready_i = sw_ready;

  logic [2:0]     s_valid, s_ready, s_sticky;
  logic [SWR-1:0] s_data [3];
  assign s_valid  = {sb2.valid_o, sb1.valid_o, sb0.valid_o};
  assign s_ready  = {sb2.ready_o, sb1.ready_o, sb0.ready_o};
  assign s_sticky = {sb2.sticky_o, sb1.sticky_o, sb0.sticky_o};
  assign s_data[0] = sb0.Data_o;
  assign s_data[1] = sb1.Data_o;
  assign s_data[2] = sb2.Data_o;

  // Scoreboard state
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   exp_e;
  logic [W-1:0]   exp_arr [64];
  logic [SWR-1:0] sw_vec [64];
  logic [SWR-1:0] hold_d;
  logic           hold_s, hold_v, low_seen;
  int             wi, got, stall_cnt;
  int             lat [3];
  int             nout [3];
  logic           st_left [6];
  logic [EWR-1:0] st_amt [6];
  logic [SWR-1:0] st_data [6];

  // Direct whole-word reference: result = (d shifted) | fill mask, sticky = data bits below the cut.
  function automatic logic [W-1:0] ref_f(input logic left, input logic fill,
                                         input logic [EWR-1:0] amt, input logic [SWR-1:0] d);
    logic [SWR-1:0] ones, r, lost;
    ones = '1;
    if (left) begin
      r = (d << amt) | (fill ? ~(ones << amt) : '0);
      return {1'b0, r};
    end
    r    = (d >> amt) | (fill ? ~(ones >> amt) : '0);
    lost = d & ~(ones << amt);
    return {|lost, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic left, input logic fill,
                     input logic [EWR-1:0] amt, input logic [SWR-1:0] d);
    bus.valid_i       = v;
    bus.left_right_i  = left;
    bus.bit_shift_i   = fill;
    bus.Shift_Value_i = amt;
    bus.Data_i        = d;
  endtask

  // One isolated word on the default instance; controls are scrambled right after accept.
  task automatic run_one(input string tag, input logic left, input logic fill,
                         input logic [EWR-1:0] amt, input logic [SWR-1:0] d,
                         input logic [SWR-1:0] exp_d, input logic exp_s);
    int n;
    put(1'b1, left, fill, amt, d);
    #1;
    check({tag, ".ready_o"}, bus.ready_o, 1);
    step();
    put(1'b0, ~left, ~fill, ~amt, ~d);
    n = 1;
    while (!bus.valid_o && n < 10) begin
      step();
      n++;
    end
    check({tag, ".latency"}, n, 2);
    check({tag, ".data"}, bus.Data_o, exp_d);
    check({tag, ".sticky"}, bus.sticky_o, exp_s);
    step();
  endtask

  initial begin
    put(1'b0, 1'b0, 1'b0, '0, '0);
    bus.ready_i = 1'b1;
    sw_valid = 1'b0; sw_left = 1'b0; sw_fill = 1'b0; sw_amt = '0; sw_data = '0; sw_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid_o", bus.valid_o, 0);
    check("rst.ready_o", bus.ready_o, 0);
    check("rst.data_o", bus.Data_o, 0);
    check("rst.sticky_o", bus.sticky_o, 0);
    #2 rst = 1'b1;
    step();

    // Single directed words
    run_one("r4_ff",      1'b0, 1'b0, 5'd4,  26'h00000FF, 26'h000000F, 1'b1);
    run_one("l25",        1'b1, 1'b0, 5'd25, 26'h0000001, 26'h2000000, 1'b0);
    run_one("l0",         1'b1, 1'b0, 5'd0,  26'h0000001, 26'h0000001, 1'b0);
    run_one("r31_f0",     1'b0, 1'b0, 5'd31, 26'h0000001, 26'h0000000, 1'b1);
    run_one("r31_f1",     1'b0, 1'b1, 5'd31, 26'h0000001, 26'h3FFFFFF, 1'b1);
    run_one("r0",         1'b0, 1'b0, 5'd0,  26'h2ABCDEF, 26'h2ABCDEF, 1'b0);
    run_one("l4_f1",      1'b1, 1'b1, 5'd4,  26'h0000001, 26'h000001F, 1'b0);
    run_one("r1_f1",      1'b0, 1'b1, 5'd1,  26'h0000003, 26'h2000001, 1'b1);
    run_one("r26_f1_z",   1'b0, 1'b1, 5'd26, 26'h0000000, 26'h3FFFFFF, 1'b0);
    run_one("r25",        1'b0, 1'b0, 5'd25, 26'h2000000, 26'h0000001, 1'b0);
    run_one("l31_f1",     1'b1, 1'b1, 5'd31, 26'h2AAAAAA, 26'h3FFFFFF, 1'b0);
    run_one("r13",        1'b0, 1'b0, 5'd13, 26'h3FFE000, 26'h0001FFF, 1'b0);

    // Six-word stream with a three-cycle downstream stall
    st_left = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    st_amt  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    st_data = '{26'h0000F0F, 26'h1234567, 26'h3C00007, 26'h0ABCDEF, 26'h2000021, 26'h3FFFFFF};
    exp_q.delete();
    wi = 0; got = 0; low_seen = 1'b0; hold_v = 1'b0; hold_d = '0; hold_s = 1'b0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      bus.ready_i = !(c >= 2 && c < 5);
      if (wi < 6) put(1'b1, st_left[wi], 1'b0, st_amt[wi], st_data[wi]);
      else        put(1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      if (!bus.ready_o) low_seen = 1'b1;
      if (hold_v) begin
        check("stall.data_o", bus.Data_o, hold_d);
        check("stall.sticky_o", bus.sticky_o, hold_s);
      end
      hold_v = bus.valid_o && !bus.ready_i;
      hold_d = bus.Data_o;
      hold_s = bus.sticky_o;
      if (bus.valid_o && bus.ready_i) begin
        check("stream.q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("stream.data_o", bus.Data_o, exp_e[SWR-1:0]);
          check("stream.sticky_o", bus.sticky_o, exp_e[SWR]);
        end
        got++;
      end
      if (bus.valid_i && bus.ready_o) begin
        exp_q.push_back(ref_f(st_left[wi], 1'b0, st_amt[wi], st_data[wi]));
        wi++;
      end
      @(posedge clk);
      #1;
    end
    put(1'b0, 1'b0, 1'b0, '0, '0);
    bus.ready_i = 1'b1;
    check("stream.count", got, 6);
    check("stream.ready_dropped", low_seen, 1);
    check("stream.q_empty", exp_q.size(), 0);
    step();

    // Asynchronous reset with two words in flight
    put(1'b1, 1'b0, 1'b0, 5'd4, 26'h00000FF);
    step();
    put(1'b1, 1'b1, 1'b0, 5'd2, 26'h0000005);
    step();
    put(1'b0, 1'b0, 1'b0, '0, '0);
    check("arst.inflight", bus.valid_o, 1);
    #2 rst = 1'b0;
    #1;
    check("arst.valid_o", bus.valid_o, 0);
    check("arst.data_o", bus.Data_o, 0);
    check("arst.sticky_o", bus.sticky_o, 0);
    check("arst.ready_o", bus.ready_o, 0);
    step();
    step();
    #2 rst = 1'b1;
    step();
    run_one("arst.post", 1'b0, 1'b1, 5'd3, 26'h0000010, 26'h3800002, 1'b0);
    for (int c = 0; c < 4; c++) begin
      check("arst.no_stale", bus.valid_o, 0);
      step();
    end

    // PIPE_CUT sweep: latency of a lone word, then all shifts in both directions
    sw_valid = 1'b1; sw_left = 1'b0; sw_fill = 1'b0; sw_amt = 5'd5; sw_data = 26'h3FFFFFF;
    #1;
    check("sweep.ready_o", s_ready, 3'b111);
    lat = '{0, 0, 0};
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n == 1) sw_valid = 1'b0;
      for (int i = 0; i < 3; i++)
        if (s_valid[i] && lat[i] == 0) lat[i] = n;
    end
    check("sweep.lat_00000", lat[0], 1);
    check("sweep.lat_01010", lat[1], 3);
    check("sweep.lat_01111", lat[2], 5);

    for (int j = 0; j < 64; j++) sw_vec[j] = SWR'($urandom());
    wi = 0; stall_cnt = 0; nout = '{0, 0, 0};
    for (int c = 0; c < 120 && (nout[0] < 64 || nout[1] < 64 || nout[2] < 64); c++) begin
      if (wi < 64) begin
        sw_valid = 1'b1;
        sw_left  = wi[5];
        sw_amt   = wi[4:0];
        sw_fill  = (wi % 3) == 0;
        sw_data  = sw_vec[wi];
      end else begin
        sw_valid = 1'b0;
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        if (s_valid[i]) begin
          check("sweep.in_order", nout[i] < wi, 1);
          if (nout[i] < wi) begin
            check("sweep.data_o", s_data[i], exp_arr[nout[i]][SWR-1:0]);
            check("sweep.sticky_o", s_sticky[i], exp_arr[nout[i]][SWR]);
          end
          nout[i]++;
        end
      end
      if (sw_valid) begin
        if (&s_ready) begin
          exp_arr[wi] = ref_f(sw_left, sw_fill, sw_amt, sw_data);
          wi++;
        end else begin
          stall_cnt++;
        end
      end
      @(posedge clk);
      #1;
    end
    sw_valid = 1'b0;
    check("sweep.count_00000", nout[0], 64);
    check("sweep.count_01010", nout[1], 64);
    check("sweep.count_01111", nout[2], 64);
    check("sweep.no_stall", stall_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
